// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_pkg: shared types and constants for the unified-memory arbiter.
//   state_e : arbiter FSM states (ST_IDLE, ST_BUSY)
//   owner_e : which requester owns the memory (OWN_IF, OWN_LSU)
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   CMD_* : default bus command values
package riscv_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } owner_e;

    // Fetch is read-only: its memory commands are always full-word loads.
    localparam logic CMD_IF_WE   = 1'b0;
    localparam logic CMD_IDLE_WE = 1'b0;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundles the fetch port, LSU port and memory port of
// the arbiter.
//   slave  modport : arbiter side (takes if_/lsu_ requests and mem_ack/rdata,
//                    drives gnt/rvalid/rdata/err and the mem_* command)
//   master modport : environment side (requesters + memory)
// Signals: if_req/if_addr -> if_gnt/if_rvalid/if_rdata/if_err
//          lsu_req/we/be/addr/wdata -> lsu_gnt/rvalid/rdata/err
//          mem_req/we/be/addr/wdata -> mem_ack/mem_rdata
interface riscv_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_err;

    logic                  lsu_req;
    logic                  lsu_we;
    logic [DATA_W/8-1:0]   lsu_be;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic                  lsu_gnt;
    logic                  lsu_rvalid;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  lsu_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/riscv_mem_arbiter_pick.sv
// mem_arb_pick: combinational winner select for the memory arbiter.
// Ports:
//   if_req, lsu_req : pending requests
//   last_owner      : requester granted most recently
//   winner          : selected owner (OWN_IF when nothing is pending)
// Build option: ARB_RR_EN selects round-robin on conflicts; otherwise LSU
// always has priority over IF.
module mem_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic   if_req,
    input  logic   lsu_req,
    input  owner_e last_owner,
    output owner_e winner
);

`ifdef ARB_RR_EN
    always_comb begin
        winner = OWN_IF;
        if (if_req && lsu_req) begin
            // Conflict: whoever was not granted last goes first.
            winner = (last_owner == OWN_IF) ? OWN_LSU : OWN_IF;
        end else if (lsu_req) begin
            winner = OWN_LSU;
        end
    end
`else
    // Fixed priority only needs lsu_req; the other inputs are kept so both
    // builds share one port list.
    logic w_unused_pick;
    assign w_unused_pick = if_req ^ (last_owner == OWN_LSU);

    always_comb begin
        winner = OWN_IF;
        if (lsu_req) begin
            winner = OWN_LSU;
        end
    end
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port memory between instruction fetch
// (read-only) and the load/store unit. One transaction outstanding at a time,
// variable memory latency via mem_ack, watchdog abort after TIMEOUT_CYC busy
// cycles (0 disables it).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : riscv_mem_arbiter_if.slave (fetch, LSU and memory ports)
// Build option: ARB_RR_EN (round-robin arbitration, see mem_arb_pick).
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    riscv_mem_arbiter_if.slave bus
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    state_e              r_state,      w_state;
    owner_e              r_owner,      w_owner;
    owner_e              r_last_owner, w_last_owner;
    logic [CNT_W-1:0]    r_cnt,        w_cnt;
    logic                r_mem_req,    w_mem_req;
    logic                r_mem_we,     w_mem_we;
    logic [BE_W-1:0]     r_mem_be,     w_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata;
    logic                r_if_gnt,     w_if_gnt;
    logic                r_if_rvalid,  w_if_rvalid;
    logic [DATA_W-1:0]   r_if_rdata,   w_if_rdata;
    logic                r_if_err,     w_if_err;
    logic                r_lsu_gnt,    w_lsu_gnt;
    logic                r_lsu_rvalid, w_lsu_rvalid;
    logic [DATA_W-1:0]   r_lsu_rdata,  w_lsu_rdata;
    logic                r_lsu_err,    w_lsu_err;

    owner_e              w_pick;
    logic                w_done;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_rsp_err;

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .lsu_req    (bus.lsu_req),
        .last_owner (r_last_owner),
        .winner     (w_pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_if_err     <= 1'b0;
            r_lsu_gnt    <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= '0;
            r_lsu_err    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_owner <= w_last_owner;
            r_cnt        <= w_cnt;
            r_mem_req    <= w_mem_req;
            r_mem_we     <= w_mem_we;
            r_mem_be     <= w_mem_be;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_if_gnt     <= w_if_gnt;
            r_if_rvalid  <= w_if_rvalid;
            r_if_rdata   <= w_if_rdata;
            r_if_err     <= w_if_err;
            r_lsu_gnt    <= w_lsu_gnt;
            r_lsu_rvalid <= w_lsu_rvalid;
            r_lsu_rdata  <= w_lsu_rdata;
            r_lsu_err    <= w_lsu_err;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_owner = r_last_owner;
        w_cnt        = r_cnt;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_be     = r_mem_be;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_if_gnt     = 1'b0;
        w_if_rvalid  = 1'b0;
        w_if_rdata   = r_if_rdata;
        w_if_err     = 1'b0;
        w_lsu_gnt    = 1'b0;
        w_lsu_rvalid = 1'b0;
        w_lsu_rdata  = r_lsu_rdata;
        w_lsu_err    = 1'b0;
        w_done       = 1'b0;
        w_rsp_data   = '0;
        w_rsp_err    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.if_req || bus.lsu_req) begin
                    w_state      = ST_BUSY;
                    w_owner      = w_pick;
                    w_last_owner = w_pick;
                    // Counts the first BUSY cycle, so the abort lands on
                    // BUSY cycle number TIMEOUT_CYC.
                    w_cnt        = CNT_W'(1);
                    w_mem_req    = 1'b1;
                    if (w_pick == OWN_LSU) begin
                        w_mem_we    = bus.lsu_we;
                        w_mem_be    = bus.lsu_be;
                        w_mem_addr  = bus.lsu_addr;
                        w_mem_wdata = bus.lsu_wdata;
                        w_lsu_gnt   = 1'b1;
                    end else begin
                        w_mem_we    = CMD_IF_WE;
                        w_mem_be    = '1;
                        w_mem_addr  = bus.if_addr;
                        w_mem_wdata = '0;
                        w_if_gnt    = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // An ack on the timeout edge wins over the abort.
                if (bus.mem_ack) begin
                    w_done     = 1'b1;
                    w_rsp_data = bus.mem_rdata;
                end else if ((TIMEOUT_CYC != 0) && (r_cnt == TO_VAL)) begin
                    w_done     = 1'b1;
                    w_rsp_err  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_done) begin
            w_state     = ST_IDLE;
            w_mem_req   = 1'b0;
            w_mem_we    = CMD_IDLE_WE;
            w_mem_be    = '0;
            w_mem_addr  = '0;
            w_mem_wdata = '0;
            if (r_owner == OWN_LSU) begin
                w_lsu_rvalid = 1'b1;
                w_lsu_rdata  = w_rsp_data;
                w_lsu_err    = w_rsp_err;
            end else begin
                w_if_rvalid = 1'b1;
                w_if_rdata  = w_rsp_data;
                w_if_err    = w_rsp_err;
            end
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.if_gnt     = r_if_gnt;
    assign bus.if_rvalid  = r_if_rvalid;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_err     = r_if_err;
    assign bus.lsu_gnt    = r_lsu_gnt;
    assign bus.lsu_rvalid = r_lsu_rvalid;
    assign bus.lsu_rdata  = r_lsu_rdata;
    assign bus.lsu_err    = r_lsu_err;

endmodule
